// File: rtl/timer_count_core_pkg.sv
// Shared definitions for the egg-timer time-keeping core: state
// encodings, BCD digit limits and a small BCD helper.
package timer_count_core_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

    // True when a two-digit BCD pair reads 00.
    function automatic logic bcd_is_zero(input logic [3:0] tens, input logic [3:0] ones);
        return (tens == 4'd0) && (ones == 4'd0);
    endfunction

endpackage

// File: rtl/timer_count_core_digit_pair.sv
// Two-digit BCD up/down counter with wrap at MAX_VAL. Incrementing past
// MAX_VAL wraps to 00; decrementing 00 wraps to MAX_VAL and raises
// borrow_out for that cycle so the next pair can take the borrow.
module timer_count_core_digit_pair
    import timer_count_core_pkg::*;
#(
    parameter int MAX_VAL = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       borrow_out
);

    localparam logic [3:0] MAX_T = 4'(MAX_VAL / 10);
    localparam logic [3:0] MAX_O = 4'(MAX_VAL % 10);
    localparam logic [3:0] D_MAX = 4'(DIGIT_MAX);

    logic at_max;
    logic at_zero;

    assign at_max     = (tens == MAX_T) && (ones == MAX_O);
    assign at_zero    = bcd_is_zero(tens, ones);
    assign borrow_out = dec && !clr && !inc && at_zero;

    // Digit update: clr beats inc beats dec; carries and borrows stay in BCD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            if (at_max) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones >= D_MAX) begin
                tens <= tens + 4'd1;
                ones <= 4'd0;
            end else begin
                ones <= ones + 4'd1;
            end
        end else if (dec) begin
            if (at_zero) begin
                tens <= MAX_T;
                ones <= MAX_O;
            end else if (ones == 4'd0) begin
                tens <= tens - 4'd1;
                ones <= D_MAX;
            end else begin
                ones <= ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/timer_count_core.sv
// Egg-timer time-keeping core. Holds MM:SS as four BCD digits, lets the
// debounced set buttons load it, counts down at 1 Hz on start and raises
// the alarm at 00:00 for a bounded number of cycles.
module timer_count_core
    import timer_count_core_pkg::*;
#(
    parameter int MAX_MINUTES  = 99,
    parameter int ALARM_CYCLES = 10
) (
    input  logic       pulse_1Hz,
    input  logic       reset,
    input  logic       minutes_debounce,
    input  logic       seconds_debounce,
    input  logic       start_stop_debounce,
    input  logic       clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm
);

    localparam int CNT_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_CYCLES - 1);

    state_t           state;
    logic             start_prev;
    logic             start_edge;
    logic [CNT_W-1:0] alarm_cnt;

    logic illegal_state;
    logic digit_clr;
    logic set_ok;
    logic sec_inc, min_inc;
    logic sec_dec, sec_borrow;
    logic min_borrow;
    logic time_zero;
    logic time_is_one;

    assign start_edge    = start_stop_debounce & ~start_prev;
    assign illegal_state = !(state inside {ST_SET, ST_RUN, ST_PAUSE, ST_ALARM});

    // Set inputs and countdown both yield to clear and to a start edge.
    assign set_ok    = (state == ST_SET) && !clear && !start_edge;
    assign sec_inc   = set_ok && seconds_debounce;
    assign min_inc   = set_ok && minutes_debounce;
    assign sec_dec   = (state == ST_RUN) && !clear && !start_edge;
    assign digit_clr = clear || illegal_state;

    assign time_zero   = bcd_is_zero(min_tens, min_ones) && bcd_is_zero(sec_tens, sec_ones);
    assign time_is_one = bcd_is_zero(min_tens, min_ones) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

    timer_count_core_digit_pair #(
        .MAX_VAL (SEC_TENS_MAX * 10 + DIGIT_MAX)
    ) u_seconds (
        .clk        (pulse_1Hz),
        .rst        (reset),
        .clr        (digit_clr),
        .inc        (sec_inc),
        .dec        (sec_dec),
        .tens       (sec_tens),
        .ones       (sec_ones),
        .borrow_out (sec_borrow)
    );

    // Minutes only ever count down on a seconds borrow (SS 00 -> 59).
    timer_count_core_digit_pair #(
        .MAX_VAL (MAX_MINUTES)
    ) u_minutes (
        .clk        (pulse_1Hz),
        .rst        (reset),
        .clr        (digit_clr),
        .inc        (min_inc),
        .dec        (sec_borrow),
        .tens       (min_tens),
        .ones       (min_ones),
        .borrow_out (min_borrow)
    );

    // Start edge detect, state machine, registered status flags and alarm timer.
    always_ff @(posedge pulse_1Hz or posedge reset) begin
        if (reset) begin
            state      <= ST_SET;
            running    <= 1'b0;
            alarm      <= 1'b0;
            start_prev <= 1'b1;
            alarm_cnt  <= '0;
        end else begin
            start_prev <= start_stop_debounce;
            if (clear) begin
                state     <= ST_SET;
                running   <= 1'b0;
                alarm     <= 1'b0;
                alarm_cnt <= '0;
            end else begin
                case (state)
                    ST_SET: begin
                        if (start_edge && !time_zero) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (start_edge) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end else if (time_is_one) begin
                            // This edge's decrement lands on 00:00.
                            state     <= ST_ALARM;
                            running   <= 1'b0;
                            alarm     <= 1'b1;
                            alarm_cnt <= '0;
                        end
                    end
                    ST_PAUSE: begin
                        if (start_edge) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_ALARM: begin
                        if (start_edge || (alarm_cnt == CNT_LAST)) begin
                            state     <= ST_SET;
                            alarm     <= 1'b0;
                            alarm_cnt <= '0;
                        end else begin
                            alarm_cnt <= alarm_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= ST_SET;
                        running   <= 1'b0;
                        alarm     <= 1'b0;
                        alarm_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // The minutes borrow has no consumer; the countdown never passes 00:00.
    logic unused_ok;
    assign unused_ok = min_borrow;

endmodule

// File: tb/tb_timer_count_core.sv
// Directed bench for timer_count_core: reset, set wraps, countdown to
// alarm, pause/resume and clear/start priority, hand-computed values.
module tb_timer_count_core;

    logic       pulse_1Hz = 1'b0;
    logic       reset = 1'b1;
    logic       minutes_debounce = 1'b0;
    logic       seconds_debounce = 1'b0;
    logic       start_stop_debounce = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, alarm;

    int checks = 0;
    int errors = 0;

    timer_count_core #(.MAX_MINUTES(99), .ALARM_CYCLES(10)) dut (
        .pulse_1Hz           (pulse_1Hz),
        .reset               (reset),
        .minutes_debounce    (minutes_debounce),
        .seconds_debounce    (seconds_debounce),
        .start_stop_debounce (start_stop_debounce),
        .clear               (clear),
        .min_tens            (min_tens),
        .min_ones            (min_ones),
        .sec_tens            (sec_tens),
        .sec_ones            (sec_ones),
        .running             (running),
        .alarm               (alarm)
    );

    always #5 pulse_1Hz = ~pulse_1Hz;

    function automatic logic [15:0] mmss();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge pulse_1Hz);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(1); clear = 1'b0;
    endtask

    task automatic set_time(input int mm, input int ss);
        do_clear();
        minutes_debounce = 1'b1; tick(mm); minutes_debounce = 1'b0;
        seconds_debounce = 1'b1; tick(ss); seconds_debounce = 1'b0;
    endtask

    logic seen59, wrap;

    initial begin
        // Reset state
        tick(2);
        chk("rst_time", mmss(), 16'h0000);
        chk("rst_run", 16'(running), 16'h0);
        chk("rst_alarm", 16'(alarm), 16'h0);
        reset = 1'b0;
        tick(1);

        // 1. Reset mid-RUN at 03:27, start held across release
        set_time(3, 27);
        chk("t1_set", mmss(), 16'h0327);
        start_stop_debounce = 1'b1; tick(1);
        chk("t1_run", 16'(running), 16'h1);
        chk("t1_run_time", mmss(), 16'h0327);
        #2 reset = 1'b1; #1;
        chk("t1_async_time", mmss(), 16'h0000);
        chk("t1_async_run", 16'(running), 16'h0);
        chk("t1_async_alarm", 16'(alarm), 16'h0);
        tick(1);
        reset = 1'b0;
        set_time(0, 3);
        start_stop_debounce = 1'b1;
        // Start level is now "held" after a fresh reset release.
        reset = 1'b1; tick(1); reset = 1'b0;
        tick(3);
        chk("t1_no_run", 16'(running), 16'h0);
        start_stop_debounce = 1'b0; tick(1);

        // 2. Seconds held 62 cycles from 00:00
        do_clear();
        seen59 = 1'b0; wrap = 1'b0;
        seconds_debounce = 1'b1;
        for (int i = 0; i < 62; i++) begin
            tick(1);
            if (mmss() == 16'h0059) seen59 = 1'b1;
            else if (seen59 && mmss() == 16'h0000) wrap = 1'b1;
        end
        seconds_debounce = 1'b0;
        chk("t2_value", mmss(), 16'h0002);
        chk("t2_wrap", 16'(wrap), 16'h1);

        // 3. Minutes wrap 99 -> 00, then both inputs at 05:59
        set_time(98, 0);
        chk("t3_start", mmss(), 16'h9800);
        seen59 = 1'b0; wrap = 1'b0;
        minutes_debounce = 1'b1;
        for (int i = 0; i < 99; i++) begin
            tick(1);
            if (mmss() == 16'h9900) seen59 = 1'b1;
            else if (seen59 && mmss() == 16'h0000) wrap = 1'b1;
        end
        minutes_debounce = 1'b0;
        chk("t3_value", mmss(), 16'h9700);
        chk("t3_wrap", 16'(wrap), 16'h1);
        set_time(5, 59);
        minutes_debounce = 1'b1; seconds_debounce = 1'b1; tick(1);
        minutes_debounce = 1'b0; seconds_debounce = 1'b0;
        chk("t3_both", mmss(), 16'h0600);

        // 4. 01:00 countdown to alarm and auto-return
        set_time(1, 0);
        start_stop_debounce = 1'b1; tick(1);
        chk("t4_edge_time", mmss(), 16'h0100);
        start_stop_debounce = 1'b0; tick(1);
        chk("t4_first_dec", mmss(), 16'h0059);
        tick(58);
        chk("t4_0001", mmss(), 16'h0001);
        chk("t4_0001_run", 16'(running), 16'h1);
        tick(1);
        chk("t4_zero", mmss(), 16'h0000);
        chk("t4_alarm", 16'(alarm), 16'h1);
        chk("t4_stopped", 16'(running), 16'h0);
        tick(9);
        chk("t4_alarm_9", 16'(alarm), 16'h1);
        tick(1);
        chk("t4_alarm_off", 16'(alarm), 16'h0);
        // Back in SET: seconds input works again
        seconds_debounce = 1'b1; tick(1); seconds_debounce = 1'b0;
        chk("t4_in_set", mmss(), 16'h0001);

        // 5. Pause at 00:30 and resume
        set_time(0, 31);
        start_stop_debounce = 1'b1; tick(1);
        start_stop_debounce = 1'b0; tick(1);
        chk("t5_run30", mmss(), 16'h0030);
        start_stop_debounce = 1'b1; tick(1);
        start_stop_debounce = 1'b0;
        chk("t5_pause", 16'(running), 16'h0);
        tick(5);
        chk("t5_hold", mmss(), 16'h0030);
        start_stop_debounce = 1'b1; tick(1);
        start_stop_debounce = 1'b0;
        chk("t5_resume", mmss(), 16'h0030);
        chk("t5_resume_run", 16'(running), 16'h1);
        tick(1);
        chk("t5_dec", mmss(), 16'h0029);

        // 6. Start at 00:00 ignored; clear beats start; start exits alarm
        do_clear();
        start_stop_debounce = 1'b1; tick(1);
        start_stop_debounce = 1'b0;
        chk("t6_zero_start", 16'(running), 16'h0);
        tick(1);
        chk("t6_zero_hold", mmss(), 16'h0000);
        set_time(2, 11);
        start_stop_debounce = 1'b1; tick(1);
        start_stop_debounce = 1'b0; tick(1);
        chk("t6_run210", mmss(), 16'h0210);
        start_stop_debounce = 1'b1; clear = 1'b1; tick(1);
        start_stop_debounce = 1'b0; clear = 1'b0;
        chk("t6_clear_time", mmss(), 16'h0000);
        chk("t6_clear_run", 16'(running), 16'h0);
        set_time(0, 2);
        start_stop_debounce = 1'b1; tick(1);
        start_stop_debounce = 1'b0; tick(2);
        chk("t6_alarm_on", 16'(alarm), 16'h1);
        start_stop_debounce = 1'b1; tick(1);
        start_stop_debounce = 1'b0;
        chk("t6_alarm_stop", 16'(alarm), 16'h0);
        chk("t6_alarm_time", mmss(), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
